// File: rtl/sys_arr_pkg.sv
// Shared types and default sizing for the GSAU systolic-array tile sequencer.
package sys_arr_pkg;

  localparam int unsigned DIM_DEF          = 4;
  localparam int unsigned MAX_INFLIGHT_DEF = 16;
  localparam int unsigned TAG_W_DEF        = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WLOAD  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } gsau_seq_state_t;

  typedef logic [TAG_W_DEF-1:0] vdst_tag_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a combinational head read; the head of a push is visible one cycle later.
module sync_fifo #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned FIFODEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_en,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 empty,
  output logic                 full
);

  localparam int unsigned PTR_W = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFODEPTH + 1);

  logic [DATAWIDTH-1:0] mem [FIFODEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 wr_fire;
  logic                 rd_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFODEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFODEPTH));
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; empty/count guard every read.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_fire) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_fire && !rd_fire)      count <= count + CNT_W'(1);
      else if (rd_fire && !wr_fire) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/gsau_tile_sequencer.sv
// Orders weight-load / stream / drain phases of the systolic array and tags returning rows.
// Optional perf counters enabled by defining GSAU_SEQ_PERF_EN.
module gsau_tile_sequencer
  import sys_arr_pkg::*;
#(
  parameter int unsigned DIM          = DIM_DEF,
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int unsigned TAG_W        = TAG_W_DEF
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 cmd_valid,
  input  logic                                 cmd_weight,
  input  logic [TAG_W-1:0]                     cmd_vdst,
  output logic                                 cmd_ready,
  input  logic                                 sa_fifo_has_space,
  output logic                                 sa_weight_en,
  output logic                                 sa_input_en,
  input  logic                                 sa_out_valid,
  output logic                                 sa_output_ready,
  input  logic                                 wb_output_ready,
  output logic                                 wb_valid,
  output logic [TAG_W-1:0]                     wb_wbdst,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]    inflight,
  output logic                                 busy,
`ifdef GSAU_SEQ_PERF_EN
  output logic [31:0]                          perf_stall_cycles,
  output logic [31:0]                          perf_rows_issued,
  output logic [31:0]                          perf_tiles,
`endif
  output logic                                 err_orphan
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned ROW_W = (DIM > 1) ? $clog2(DIM) : 1;

  gsau_seq_state_t  state;
  logic [ROW_W-1:0] wrow;
  logic             last_row;
  logic             act_ok;
  logic             tile_done;
  logic             pop;
  logic             orphan;
  logic             tag_empty;
  logic             tag_full;
  logic [TAG_W-1:0] tag_head;
  logic             fifo_rstn;

  assign last_row = (wrow == ROW_W'(DIM - 1));
  assign act_ok   = sa_fifo_has_space && !tag_full && (inflight < CNT_W'(MAX_INFLIGHT));

  // Combinational command handshake; everything is held low while reset is asserted.
  always_comb begin
    cmd_ready = 1'b0;
    case (state)
      IDLE, WLOAD: cmd_ready = cmd_weight && sa_fifo_has_space;
      STREAM:      cmd_ready = !cmd_weight && act_ok;
      default:     cmd_ready = 1'b0;
    endcase
    if (RST) cmd_ready = 1'b0;
    sa_weight_en = cmd_valid && cmd_ready && cmd_weight;
    sa_input_en  = cmd_valid && cmd_ready && !cmd_weight;
  end

  assign tile_done = sa_weight_en && (((state == WLOAD) && last_row) || ((state == IDLE) && (DIM == 1)));

  assign sa_output_ready = wb_output_ready && !RST;
  assign wb_valid        = sa_out_valid && !tag_empty && !RST;
  assign wb_wbdst        = tag_empty ? '0 : tag_head;
  assign pop             = sa_out_valid && sa_output_ready && !tag_empty;
  assign orphan          = sa_out_valid && sa_output_ready && tag_empty;
  assign busy            = (state != IDLE);
  assign fifo_rstn       = ~RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      wrow       <= '0;
      inflight   <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (orphan) err_orphan <= 1'b1;

      if (sa_input_en && !pop)      inflight <= inflight + CNT_W'(1);
      else if (pop && !sa_input_en) inflight <= inflight - CNT_W'(1);

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_weight) begin
            if (tile_done) begin
              state <= STREAM;
              wrow  <= '0;
            end else begin
              state <= WLOAD;
              wrow  <= sa_weight_en ? ROW_W'(1) : '0;
            end
          end
        end
        WLOAD: begin
          if (sa_weight_en) begin
            if (last_row) begin
              state <= STREAM;
              wrow  <= '0;
            end else begin
              wrow <= wrow + ROW_W'(1);
            end
          end
        end
        STREAM: begin
          // A weight row at the head ends the stream phase; it waits for the array to empty.
          if (cmd_valid && cmd_weight) state <= DRAIN;
        end
        DRAIN: begin
          if (inflight == '0) state <= WLOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DATAWIDTH (TAG_W),
    .FIFODEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk     (CLK),
    .rstn    (fifo_rstn),
    .wr_en   (sa_input_en),
    .wr_data (cmd_vdst),
    .rd_en   (pop),
    .rd_data (tag_head),
    .empty   (tag_empty),
    .full    (tag_full)
  );

`ifdef GSAU_SEQ_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_stall_cycles <= '0;
      perf_rows_issued  <= '0;
      perf_tiles        <= '0;
    end else begin
      if (cmd_valid && !cmd_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (sa_input_en)             perf_rows_issued  <= perf_rows_issued + 32'd1;
      if (tile_done)               perf_tiles        <= perf_tiles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gsau_tile_sequencer.sv
// Directed bench for gsau_tile_sequencer with a tag scoreboard for the return path.
module tb_gsau_tile_sequencer;
  import sys_arr_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_weight = 1'b0;
  logic [7:0] cmd_vdst = '0;
  logic       cmd_ready;
  logic       sa_fifo_has_space = 1'b0;
  logic       sa_weight_en;
  logic       sa_input_en;
  logic       sa_out_valid = 1'b0;
  logic       sa_output_ready;
  logic       wb_output_ready = 1'b0;
  logic       wb_valid;
  logic [7:0] wb_wbdst;
  logic [4:0] inflight;
  logic       busy;
  logic       err_orphan;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb[$];

  gsau_tile_sequencer #(.DIM(4), .MAX_INFLIGHT(16), .TAG_W(8)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .cmd_valid         (cmd_valid),
    .cmd_weight        (cmd_weight),
    .cmd_vdst          (cmd_vdst),
    .cmd_ready         (cmd_ready),
    .sa_fifo_has_space (sa_fifo_has_space),
    .sa_weight_en      (sa_weight_en),
    .sa_input_en       (sa_input_en),
    .sa_out_valid      (sa_out_valid),
    .sa_output_ready   (sa_output_ready),
    .wb_output_ready   (wb_output_ready),
    .wb_valid          (wb_valid),
    .wb_wbdst          (wb_wbdst),
    .inflight          (inflight),
    .busy              (busy),
    .err_orphan        (err_orphan)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic cv, input logic cw, input logic [7:0] vd,
                        input logic sp, input logic ov, input logic wr);
    cmd_valid = cv; cmd_weight = cw; cmd_vdst = vd;
    sa_fifo_has_space = sp; sa_out_valid = ov; wb_output_ready = wr;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expect a tagged return this cycle matching the oldest issued row.
  task automatic expect_ret(input string tag);
    logic [7:0] exp_tag;
    check({tag, "_valid"}, 32'(wb_valid), 32'd1);
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=pending_tag", tag);
    end
    if (sb.size() != 0) begin
      exp_tag = sb.pop_front();
      check({tag, "_tag"}, 32'(wb_wbdst), 32'(exp_tag));
    end
  endtask

  task automatic issue_act(input logic [7:0] vd, input string tag);
    set_in(1'b1, 1'b0, vd, 1'b1, 1'b0, 1'b1);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_input_en"}, 32'(sa_input_en), 32'd1);
    sb.push_back(vd);
    tick();
  endtask

  initial begin
    // Reset with every input active: all outputs must stay low.
    set_in(1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b1);
    #10;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_weight_en", 32'(sa_weight_en), 32'd0);
    check("rst_out_ready", 32'(sa_output_ready), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wbdst", 32'(wb_wbdst), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_orphan), 32'd0);
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // Activation in IDLE is refused.
    set_in(1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1);
    check("idle_act_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("idle_state", 32'(dut.state), 32'(IDLE));

    // Tile load: four weight rows on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
      check($sformatf("wload%0d_ready", i), 32'(cmd_ready), 32'd1);
      check($sformatf("wload%0d_wen", i), 32'(sa_weight_en), 32'd1);
      tick();
    end
    check("tile_state_stream", 32'(dut.state), 32'(STREAM));
    check("tile_busy", 32'(busy), 32'd1);

    // Back-pressure: fill to MAX_INFLIGHT.
    for (int i = 0; i < 16; i++) issue_act(8'(8'h10 + i), $sformatf("fill%0d", i));
    check("full_inflight", 32'(inflight), 32'd16);
    set_in(1'b1, 1'b0, 8'h20, 1'b1, 1'b1, 1'b1);
    check("row17_blocked", 32'(cmd_ready), 32'd0);
    check("row17_no_issue", 32'(sa_input_en), 32'd0);
    expect_ret("bp_ret");
    tick();
    issue_act(8'h20, "row17");
    check("row17_inflight", 32'(inflight), 32'd16);

    // Writeback not ready: result shown but not consumed.
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    check("wbstall_out_ready", 32'(sa_output_ready), 32'd0);
    check("wbstall_valid", 32'(wb_valid), 32'd1);
    tick();
    check("wbstall_inflight", 32'(inflight), 32'd16);

    // Return down to three in flight.
    for (int i = 0; i < 13; i++) begin
      set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      expect_ret($sformatf("ret%0d", i));
      tick();
    end
    check("three_inflight", 32'(inflight), 32'd3);

    // Simultaneous push and pop keep inflight and order.
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 8'(8'h30 + i), 1'b1, 1'b1, 1'b1);
      check($sformatf("pp%0d_ready", i), 32'(cmd_ready), 32'd1);
      expect_ret($sformatf("pp%0d", i));
      sb.push_back(8'(8'h30 + i));
      tick();
      check($sformatf("pp%0d_inflight", i), 32'(inflight), 32'd3);
    end
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    expect_ret("pp_tail");
    tick();
    check("two_inflight", 32'(inflight), 32'd2);

    // Weight reload while rows are in flight.
    set_in(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    check("reload_ready", 32'(cmd_ready), 32'd0);
    check("reload_wen", 32'(sa_weight_en), 32'd0);
    tick();
    check("reload_drain", 32'(dut.state), 32'(DRAIN));
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
      check($sformatf("drain%0d_ready", i), 32'(cmd_ready), 32'd0);
      expect_ret($sformatf("drain%0d", i));
      tick();
    end
    set_in(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    check("drain_empty_state", 32'(dut.state), 32'(DRAIN));
    check("drain_empty_ready", 32'(cmd_ready), 32'd0);
    check("drain_empty_inflight", 32'(inflight), 32'd0);
    tick();
    check("reload_wload", 32'(dut.state), 32'(WLOAD));
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
      check($sformatf("rl%0d_wen", i), 32'(sa_weight_en), 32'd1);
      tick();
    end
    check("reload_stream", 32'(dut.state), 32'(STREAM));

    // Orphan output with empty tag FIFO.
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    check("orphan_wb_valid", 32'(wb_valid), 32'd0);
    check("orphan_err_pre", 32'(err_orphan), 32'd0);
    tick();
    check("orphan_err", 32'(err_orphan), 32'd1);
    check("orphan_inflight", 32'(inflight), 32'd0);
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    check("orphan_sticky", 32'(err_orphan), 32'd1);

    // Reset mid-stream with five rows in flight.
    for (int i = 0; i < 5; i++) issue_act(8'(8'h40 + i), $sformatf("pre_rst%0d", i));
    check("pre_rst_inflight", 32'(inflight), 32'd5);
    set_in(1'b1, 1'b0, 8'h45, 1'b1, 1'b1, 1'b1);
    RST = 1'b1;
    #1;
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_input_en", 32'(sa_input_en), 32'd0);
    check("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
    check("mid_rst_wbdst", 32'(wb_wbdst), 32'd0);
    check("mid_rst_inflight", 32'(inflight), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err_orphan), 32'd0);
    sb.delete();
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    check("post_rst_state", 32'(dut.state), 32'(IDLE));
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("post_rst_fifo_empty", 32'(wb_valid), 32'd0);
    tick();
    check("post_rst_orphan", 32'(err_orphan), 32'd1);
    check("post_rst_inflight", 32'(inflight), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
